// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive/transmit path and the line buffer.
package uart_pkg;

  localparam logic [7:0] ASCII_CR  = 8'h0D;
  localparam logic [7:0] ASCII_LF  = 8'h0A;
  localparam logic [7:0] ASCII_BS  = 8'h08;
  localparam logic [7:0] ASCII_DEL = 8'h7F;

  typedef logic [7:0] byte_t;

endpackage

// File: rtl/line_buf_mem.sv
// Byte storage for the line buffer: one synchronous write port, one asynchronous read port.
module line_buf_mem
  import uart_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  byte_t         wdata,
  input  logic [AW-1:0] raddr,
  output byte_t         rdata
);

  byte_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_line_buffer.sv
// Line-mode buffer between uart_rx and uart_tx: bytes are edited with backspace and
// released downstream only after a terminator arrives or the buffer fills.
module uart_line_buffer
  import uart_pkg::*;
#(
  parameter int    DEPTH     = 64,
  parameter byte_t TERM_CHAR = ASCII_CR,
  parameter byte_t BS_CHAR0  = ASCII_BS,
  parameter byte_t BS_CHAR1  = ASCII_DEL
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_axis_tvalid,
  input  logic [7:0]             s_axis_tdata,
  output logic                   s_axis_tready,
  output logic                   m_axis_tvalid,
  output logic [7:0]             m_axis_tdata,
  input  logic                   m_axis_tready,
  output logic [$clog2(DEPTH):0] pending_bytes,
  output logic                   forced_commit
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);

  logic [AW:0] wr_ptr_reg, wr_ptr_next;
  logic [AW:0] commit_ptr_reg, commit_ptr_next;
  logic [AW:0] rd_ptr_reg, rd_ptr_next;
  logic        forced_reg, forced_next;

  logic [AW:0] occupancy;
  logic [AW:0] wr_inc;
  logic        in_fire, out_fire, is_bs, mem_we;

  assign occupancy     = wr_ptr_reg - rd_ptr_reg;
  assign wr_inc        = wr_ptr_reg + 1'b1;
  assign s_axis_tready = (occupancy != FULL_OCC);
  assign m_axis_tvalid = (rd_ptr_reg != commit_ptr_reg);
  assign pending_bytes = wr_ptr_reg - commit_ptr_reg;
  assign forced_commit = forced_reg;

  assign in_fire  = s_axis_tvalid & s_axis_tready;
  assign out_fire = m_axis_tvalid & m_axis_tready;
  assign is_bs    = (s_axis_tdata == BS_CHAR0) || (s_axis_tdata == BS_CHAR1);

  always_comb begin
    wr_ptr_next     = wr_ptr_reg;
    commit_ptr_next = commit_ptr_reg;
    rd_ptr_next     = rd_ptr_reg;
    forced_next     = 1'b0;
    mem_we          = 1'b0;

    if (in_fire) begin
      if (is_bs) begin
        // Only uncommitted bytes can be erased; a backspace on an empty line is swallowed.
        if (wr_ptr_reg != commit_ptr_reg) begin
          wr_ptr_next = wr_ptr_reg - 1'b1;
        end
      end else begin
        mem_we      = 1'b1;
        wr_ptr_next = wr_inc;
        if (s_axis_tdata == TERM_CHAR) begin
          commit_ptr_next = wr_inc;
        end else if ((wr_inc - rd_ptr_reg) == FULL_OCC) begin
          // A full, uncommitted buffer could never drain, so release it as-is.
          commit_ptr_next = wr_inc;
          forced_next     = 1'b1;
        end
      end
    end

    if (out_fire) begin
      rd_ptr_next = rd_ptr_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg     <= '0;
      commit_ptr_reg <= '0;
      rd_ptr_reg     <= '0;
      forced_reg     <= 1'b0;
    end else begin
      wr_ptr_reg     <= wr_ptr_next;
      commit_ptr_reg <= commit_ptr_next;
      rd_ptr_reg     <= rd_ptr_next;
      forced_reg     <= forced_next;
    end
  end

  line_buf_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr_reg[AW-1:0]),
    .wdata (s_axis_tdata),
    .raddr (rd_ptr_reg[AW-1:0]),
    .rdata (m_axis_tdata)
  );

endmodule

// File: tb/tb_uart_line_buffer.sv
// Randomised and directed checks of uart_line_buffer against a queue-based line model.
module tb_uart_line_buffer;
  import uart_pkg::*;

  localparam int DEPTH = 64;
  localparam int AW    = $clog2(DEPTH);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_axis_tvalid = 1'b0;
  logic [7:0]  s_axis_tdata = 8'h00;
  logic        s_axis_tready;
  logic        m_axis_tvalid;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tready = 1'b0;
  logic [AW:0] pending_bytes;
  logic        forced_commit;

  int n_checks = 0;
  int n_errors = 0;

  // Model: bytes of the line being typed, and committed bytes not yet sent.
  byte_t q_pend[$];
  byte_t q_out[$];
  logic  exp_forced = 1'b0;

  always #5 clk = ~clk;

  uart_line_buffer #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tready (s_axis_tready),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tready (m_axis_tready),
    .pending_bytes (pending_bytes),
    .forced_commit (forced_commit)
  );

  function automatic logic model_ready();
    return (q_pend.size() + q_out.size()) != DEPTH;
  endfunction

  task automatic drive(input logic v, input byte_t d, input logic r);
    @(negedge clk);
    s_axis_tvalid = v;
    s_axis_tdata  = d;
    m_axis_tready = r;
    #1;
  endtask

  // Apply one clock edge to the model using the inputs currently driven.
  task automatic advance();
    logic in_f, out_f, f_next;
    int   occ;
    in_f   = s_axis_tvalid && model_ready();
    out_f  = m_axis_tready && (q_out.size() != 0);
    occ    = q_pend.size() + q_out.size();
    f_next = 1'b0;
    if (rst) begin
      q_pend.delete();
      q_out.delete();
    end else begin
      if (out_f) void'(q_out.pop_front());
      if (in_f) begin
        if (s_axis_tdata == ASCII_BS || s_axis_tdata == ASCII_DEL) begin
          if (q_pend.size() != 0) void'(q_pend.pop_back());
        end else begin
          q_pend.push_back(s_axis_tdata);
          if (s_axis_tdata == ASCII_CR || occ + 1 == DEPTH) begin
            f_next = (s_axis_tdata != ASCII_CR);
            while (q_pend.size() != 0) q_out.push_back(q_pend.pop_front());
          end
        end
      end
    end
    @(posedge clk);
    exp_forced = f_next;
  endtask

  task automatic drain(input int n_exp, input string name);
    int cnt = 0;
    int cyc = 0;
    while (q_out.size() != 0 && cyc < 4 * DEPTH) begin
      drive(1'b0, 8'h00, 1'b1);
      n_checks++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== q_out[0]) begin
        n_errors++;
        $display("FAIL %s drain byte %0d: tvalid=%b tdata=%h required tvalid=1 tdata=%h",
                 name, cnt, m_axis_tvalid, m_axis_tdata, q_out[0]);
      end
      cnt++;
      cyc++;
      advance();
    end
    drive(1'b0, 8'h00, 1'b0);
    n_checks++;
    if (cnt !== n_exp || m_axis_tvalid !== 1'b0) begin
      n_errors++;
      $display("FAIL %s drain count: got %0d bytes tvalid=%b, required %0d bytes tvalid=0",
               name, cnt, m_axis_tvalid, n_exp);
    end
    $display("%s: drained %0d bytes", name, cnt);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 8'h00, 1'b0);
    advance();
    drive(1'b0, 8'h00, 1'b0);
    advance();
    drive(1'b0, 8'h00, 1'b0);
    rst = 1'b0;
    n_checks++;
    if (s_axis_tready !== 1'b1 || m_axis_tvalid !== 1'b0 || pending_bytes !== '0 ||
        forced_commit !== 1'b0) begin
      n_errors++;
      $display("FAIL reset: tready=%b tvalid=%b pending=%0d forced=%b required 1 0 0 0",
               s_axis_tready, m_axis_tvalid, pending_bytes, forced_commit);
    end
    advance();
    $display("reset: state checked");
  endtask

  // Send a byte sequence with the sink ready, checking visibility and pending count each cycle.
  task automatic send_checked(input byte_t seq[$], input string name);
    foreach (seq[i]) begin
      drive(1'b1, seq[i], 1'b1);
      n_checks++;
      if (s_axis_tready !== 1'b1 || m_axis_tvalid !== (q_out.size() != 0) ||
          pending_bytes !== q_pend.size()) begin
        n_errors++;
        $display("FAIL %s byte %0d: tready=%b tvalid=%b pending=%0d required 1 %b %0d",
                 name, i, s_axis_tready, m_axis_tvalid, pending_bytes,
                 q_out.size() != 0, q_pend.size());
      end
      advance();
      $display("%s: sent %h", name, seq[i]);
    end
  endtask

  task automatic test_basic_line();
    byte_t seq[$] = '{8'h41, 8'h42, 8'h0D};
    send_checked(seq, "basic");
    drive(1'b0, 8'h00, 1'b0);
    n_checks++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 8'h41 || pending_bytes !== '0) begin
      n_errors++;
      $display("FAIL basic after CR: tvalid=%b tdata=%h pending=%0d required 1 41 0",
               m_axis_tvalid, m_axis_tdata, pending_bytes);
    end
    advance();
    drain(3, "basic");
  endtask

  task automatic test_backspace();
    byte_t seq[$] = '{8'h41, 8'h58, 8'h08, 8'h42, 8'h0D};
    send_checked(seq, "backspace");
    drain(3, "backspace");
  endtask

  task automatic test_bs_empty();
    byte_t seq[$] = '{8'h08, 8'h7F, 8'h5A, 8'h0D};
    send_checked(seq, "bs_empty");
    drain(2, "bs_empty");
  endtask

  task automatic test_full();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 8'h55, 1'b0);
      n_checks++;
      if (s_axis_tready !== 1'b1 || m_axis_tvalid !== 1'b0 || forced_commit !== 1'b0) begin
        n_errors++;
        $display("FAIL full fill %0d: tready=%b tvalid=%b forced=%b required 1 0 0",
                 i, s_axis_tready, m_axis_tvalid, forced_commit);
      end
      advance();
    end
    drive(1'b0, 8'h00, 1'b0);
    n_checks++;
    if (forced_commit !== 1'b1 || s_axis_tready !== 1'b0 || m_axis_tvalid !== 1'b1 ||
        pending_bytes !== '0 || exp_forced !== 1'b1) begin
      n_errors++;
      $display("FAIL full commit: forced=%b tready=%b tvalid=%b pending=%0d required 1 0 1 0",
               forced_commit, s_axis_tready, m_axis_tvalid, pending_bytes);
    end
    advance();
    drive(1'b0, 8'h00, 1'b0);
    n_checks++;
    if (forced_commit !== 1'b0) begin
      n_errors++;
      $display("FAIL full pulse width: forced=%b required 0", forced_commit);
    end
    advance();
    drive(1'b0, 8'h00, 1'b1);
    n_checks++;
    if (s_axis_tready !== 1'b0 || m_axis_tdata !== 8'h55) begin
      n_errors++;
      $display("FAIL full first read: tready=%b tdata=%h required 0 55",
               s_axis_tready, m_axis_tdata);
    end
    advance();
    drive(1'b0, 8'h00, 1'b1);
    n_checks++;
    if (s_axis_tready !== 1'b1) begin
      n_errors++;
      $display("FAIL full tready after read: tready=%b required 1", s_axis_tready);
    end
    advance();
    $display("full: forced commit of %0d bytes", DEPTH);
    drain(DEPTH - 2, "full");
  endtask

  task automatic test_random();
    byte_t line[$];
    int    idx, len, cyc;
    logic  v, r;
    byte_t d;
    for (int ln = 0; ln < 100; ln++) begin
      line.delete();
      len = $urandom_range(1, 20);
      for (int k = 0; k < len - 1; k++) begin
        if ($urandom_range(0, 5) == 0)
          line.push_back(($urandom_range(0, 1) != 0) ? ASCII_BS : ASCII_DEL);
        else
          line.push_back(byte_t'($urandom_range(8'h20, 8'h7E)));
      end
      line.push_back(ASCII_CR);
      idx = 0;
      cyc = 0;
      while (idx < line.size() && cyc < 2000) begin
        v = ($urandom_range(0, 3) != 0);
        r = ($urandom_range(0, 2) != 0);
        d = v ? line[idx] : byte_t'($urandom_range(0, 255));
        drive(v, d, r);
        n_checks++;
        if (s_axis_tready !== model_ready() || m_axis_tvalid !== (q_out.size() != 0) ||
            pending_bytes !== q_pend.size() || forced_commit !== exp_forced ||
            (q_out.size() != 0 && m_axis_tdata !== q_out[0])) begin
          n_errors++;
          $display("FAIL random line %0d: tready=%b tvalid=%b tdata=%h pending=%0d forced=%b required %b %b %h %0d %b",
                   ln, s_axis_tready, m_axis_tvalid, m_axis_tdata, pending_bytes, forced_commit,
                   model_ready(), q_out.size() != 0, (q_out.size() != 0) ? q_out[0] : 8'h00,
                   q_pend.size(), exp_forced);
        end
        if (v && model_ready()) idx++;
        cyc++;
        advance();
      end
      if (cyc >= 2000) begin
        n_checks++;
        n_errors++;
        $display("FAIL random line %0d: not accepted within 2000 cycles", ln);
      end
      $display("random: line %0d len %0d queued %0d", ln, len, q_out.size());
    end
    drain(q_out.size(), "random");
  endtask

  task automatic test_reset_mid();
    byte_t seq[$] = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h0D,
                      8'h61, 8'h62, 8'h63};
    foreach (seq[i]) begin
      drive(1'b1, seq[i], 1'b0);
      advance();
    end
    drive(1'b0, 8'h00, 1'b0);
    n_checks++;
    if (m_axis_tvalid !== 1'b1 || pending_bytes !== 3) begin
      n_errors++;
      $display("FAIL reset_mid before: tvalid=%b pending=%0d required 1 3",
               m_axis_tvalid, pending_bytes);
    end
    rst = 1'b1;
    advance();
    drive(1'b0, 8'h00, 1'b0);
    rst = 1'b0;
    n_checks++;
    if (m_axis_tvalid !== 1'b0 || pending_bytes !== '0 || s_axis_tready !== 1'b1 ||
        q_out.size() != 0) begin
      n_errors++;
      $display("FAIL reset_mid after: tvalid=%b pending=%0d tready=%b required 0 0 1",
               m_axis_tvalid, pending_bytes, s_axis_tready);
    end
    advance();
    $display("reset_mid: 10 committed and 3 pending discarded");
  endtask

  initial begin
    test_reset();
    test_basic_line();
    test_backspace();
    test_bs_empty();
    test_full();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
